// File: rtl/bist_fail_log.sv
// BIST failure logger: captures {addr, exp, act} of each RUN-state miscompare into a depth-entry FIFO, visible 1 cycle later, drained by valid/ready.
// Full FIFO drops the record and sets sticky overflow; optional BIST_LOG_DROP_CNT_EN adds a saturating 8-bit drop_count.
module bist_fail_log #(
  parameter int a_width = 4,
  parameter int width   = 4,
  parameter int depth   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       done,
  input  logic                       cmp_valid,
  input  logic                       is_equal,
  input  logic [a_width-1:0]         address,
  input  logic [width-1:0]           data_exp,
  input  logic [width-1:0]           data_act,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [a_width-1:0]         log_addr,
  output logic [width-1:0]           log_exp,
  output logic [width-1:0]           log_act,
  output logic [$clog2(depth):0]     log_count,
  output logic                       overflow,
`ifdef BIST_LOG_DROP_CNT_EN
  output logic [7:0]                 drop_count,
`endif
  output logic                       state_run,
  output logic                       report
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;

  typedef struct packed {
    logic [a_width-1:0] addr;
    logic [width-1:0]   exp;
    logic [width-1:0]   act;
  } rec_t;

  state_e          state_q, state_d;
  logic            state_run_q, state_run_d;
  logic            report_q, report_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  rec_t            mem_q [depth];
  rec_t            head;
  logic            full, push_req, pop, push, drop, wr_en;
`ifdef BIST_LOG_DROP_CNT_EN
  logic [7:0]      drop_cnt_q, drop_cnt_d;
`endif

  assign full      = (count_q == CW'(depth));
  assign log_valid = (count_q != '0);
  assign push_req  = (state_q == RUN) && cmp_valid && !is_equal;
  assign pop       = log_valid && log_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
`ifdef BIST_LOG_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
`endif
    if (start) begin
      state_d    = RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
`ifdef BIST_LOG_DROP_CNT_EN
      drop_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (done) state_d = REPORT;
        REPORT:  if (!log_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop) begin
        overflow_d = 1'b1;
`ifdef BIST_LOG_DROP_CNT_EN
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
      end
    end
    state_run_d = (state_d == RUN);
    report_d    = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      state_run_q <= 1'b0;
      report_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
`ifdef BIST_LOG_DROP_CNT_EN
      drop_cnt_q  <= '0;
`endif
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      state_run_q <= state_run_d;
      report_q    <= report_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
`ifdef BIST_LOG_DROP_CNT_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
      if (wr_en) mem_q[wr_ptr_q] <= '{addr: address, exp: data_exp, act: data_act};
    end
  end

  assign log_addr  = head.addr;
  assign log_exp   = head.exp;
  assign log_act   = head.act;
  assign log_count = count_q;
  assign overflow  = overflow_q;
  assign state_run = state_run_q;
  assign report    = report_q;
`ifdef BIST_LOG_DROP_CNT_EN
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bist_fail_log.sv
// Bench for bist_fail_log: directed scenarios plus a random phase, all checked against a queue-based model.
module tb_bist_fail_log;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, start, done, cmp_valid, is_equal, log_ready;
  logic [AW-1:0] address;
  logic [W-1:0]  data_exp, data_act;
  logic          log_valid;
  logic [AW-1:0] log_addr;
  logic [W-1:0]  log_exp, log_act;
  logic [CW-1:0] log_count;
  logic          overflow, state_run, report;
`ifdef BIST_LOG_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  bist_fail_log #(.a_width(AW), .width(W), .depth(D)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .cmp_valid(cmp_valid), .is_equal(is_equal), .address(address),
    .data_exp(data_exp), .data_act(data_act),
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
    .log_exp(log_exp), .log_act(log_act), .log_count(log_count),
    .overflow(overflow),
`ifdef BIST_LOG_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .state_run(state_run), .report(report)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  e;
    logic [W-1:0]  x;
  } rec_t;

  // Reference model: log is a plain queue; phase 0=idle, 1=run, 2=report.
  rec_t q[$];
  int   m_phase = 0;
  bit   m_ovf   = 0;
  int   m_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  n;
    bit  pop, push;
    if (rst) begin
      q.delete(); m_phase = 0; m_ovf = 0; m_drops = 0;
    end else if (start) begin
      q.delete(); m_phase = 1; m_ovf = 0; m_drops = 0;
    end else begin
      n    = q.size();
      pop  = (n > 0) && log_ready;
      push = (m_phase == 1) && cmp_valid && !is_equal;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < D) q.push_back(rec_t'{address, data_exp, data_act});
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (m_phase == 1 && done) m_phase = 2;
      else if (m_phase == 2 && n == 0) m_phase = 0;
    end
  endtask

  task automatic compare_model();
    check("log_valid", 32'(log_valid), 32'(q.size() > 0));
    check("log_count", 32'(log_count), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("state_run", 32'(state_run), 32'(m_phase == 1));
    check("report", 32'(report), 32'(m_phase == 2));
    if (q.size() > 0) begin
      check("log_addr", 32'(log_addr), 32'(q[0].a));
      check("log_exp", 32'(log_exp), 32'(q[0].e));
      check("log_act", 32'(log_act), 32'(q[0].x));
    end
`ifdef BIST_LOG_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(log_valid), 32'd0);
    check({tag, "_count"}, 32'(log_count), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_run"}, 32'(state_run), 32'd0);
    check({tag, "_report"}, 32'(report), 32'd0);
    check({tag, "_addr"}, 32'(log_addr), 32'd0);
    check({tag, "_exp"}, 32'(log_exp), 32'd0);
    check({tag, "_act"}, 32'(log_act), 32'd0);
`ifdef BIST_LOG_DROP_CNT_EN
    check({tag, "_drops"}, 32'(drop_count), 32'd0);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_cmp(input logic [AW-1:0] a, input logic [W-1:0] e,
                        input logic [W-1:0] x, input logic eq);
    cmp_valid = 1'b1; address = a; data_exp = e; data_act = x; is_equal = eq;
    tick();
    cmp_valid = 1'b0; is_equal = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] got[$];
    rst = 1'b1; start = 1'b0; done = 1'b0; cmp_valid = 1'b0; is_equal = 1'b1;
    log_ready = 1'b0; address = '0; data_exp = '0; data_act = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Clean run
    pulse_start();
    check("clean_run_rises", 32'(state_run), 32'd1);
    for (int i = 0; i < 16; i++) do_cmp(AW'(i), W'(i), W'(i), 1'b1);
    done = 1'b1; tick(); done = 1'b0;
    check("clean_report", 32'(report), 32'd1);
    check("clean_count", 32'(log_count), 32'd0);
    tick();
    check("clean_idle", 32'({report, state_run}), 32'd0);

    // Single fail
    pulse_start();
    do_cmp(4'h5, 4'hA, 4'h8, 1'b0);
    check("single_valid", 32'(log_valid), 32'd1);
    check("single_addr", 32'(log_addr), 32'h5);
    check("single_exp", 32'(log_exp), 32'hA);
    check("single_act", 32'(log_act), 32'h8);
    log_ready = 1'b1; tick(); log_ready = 1'b0;
    check("single_popped", 32'(log_count), 32'd0);

    // Overflow: six fails into a four-entry log
    for (int i = 0; i < 6; i++) do_cmp(AW'(i), W'(15 - i), W'(i), 1'b0);
    check("ovf_count", 32'(log_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
`ifdef BIST_LOG_DROP_CNT_EN
    check("ovf_drops", 32'(drop_count), 32'd2);
`endif
    done = 1'b1; tick(); done = 1'b0;
    log_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_order", 32'(log_addr), 32'(k));
      tick();
    end
    log_ready = 1'b0;
    tick();

    // Full FIFO with push and pop in the same cycle
    pulse_start();
    for (int i = 0; i < 4; i++) do_cmp(AW'(8 + i), 4'h1, 4'h2, 1'b0);
    log_ready = 1'b1;
    do_cmp(4'hC, 4'h3, 4'h4, 1'b0);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_count", 32'(log_count), 32'd4);
    done = 1'b1;
    for (int k = 0; k < 8 && log_valid; k++) begin
      got.push_back(log_addr);
      tick();
      done = 1'b0;
    end
    done = 1'b0; log_ready = 1'b0;
    check("pp_drained", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      check("pp_first", 32'(got[0]), 32'h9);
      check("pp_last", 32'(got[3]), 32'hC);
    end
    tick();

    // Restart from REPORT with three records held
    pulse_start();
    for (int i = 0; i < 3; i++) do_cmp(AW'(i), 4'h0, 4'hF, 1'b0);
    done = 1'b1; tick(); done = 1'b0;
    check("restart_report", 32'(report), 32'd1);
    check("restart_held", 32'(log_count), 32'd3);
    pulse_start();
    check("restart_count", 32'(log_count), 32'd0);
    check("restart_run", 32'(state_run), 32'd1);

    // Reset mid-run with two records held
    for (int i = 0; i < 2; i++) do_cmp(AW'(7 + i), 4'h6, 4'h9, 1'b0);
    check("midrst_held", 32'(log_count), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_values("midrst");

    // Random phase
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 39) == 0);
      done      = ($urandom_range(0, 24) == 0);
      cmp_valid = $urandom_range(0, 1);
      is_equal  = ($urandom_range(0, 2) != 0);
      log_ready = ($urandom_range(0, 3) == 0);
      address   = AW'($urandom);
      data_exp  = W'($urandom);
      data_act  = W'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; done = 1'b0; cmp_valid = 1'b0; log_ready = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
